// File: rtl/global_predictor.sv
// rtl/global_predictor.sv - global-history branch predictor with a GHR-indexed 2-bit counter table
// Clears the table after reset, then predicts at the current GHR and trains on branch resolution.
module global_predictor #(
  parameter int HIST_BITS = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 ready,
  input  logic                 lookup_valid,
  output logic                 GPresult,
  output logic                 GPvalid,
  output logic [HIST_BITS-1:0] GPindex,
  input  logic                 update_valid,
  input  logic [HIST_BITS-1:0] update_index,
  input  logic                 BranchTaken,
  output logic [HIST_BITS-1:0] GHR
);

  localparam int DEPTH = 1 << HIST_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  logic [HIST_BITS-1:0] ptr;
  logic [1:0]           ctr_table [DEPTH];

  logic                 wr_en;
  logic [HIST_BITS-1:0] wr_addr;
  logic [1:0]           wr_data;
  logic [1:0]           upd_old;
  logic [1:0]           upd_new;

  always_comb begin
    upd_old = ctr_table[update_index];
    upd_new = upd_old;
    if (BranchTaken) begin
      if (upd_old != 2'd3) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != 2'd0) upd_new = upd_old - 2'd1;
    end
  end

  // One shared write port: INIT clears entries in order, RUN trains the resolved entry.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ptr;
    wr_data = 2'd0;
    if (!reset) begin
      if (state == INIT) begin
        wr_en = 1'b1;
      end else if (update_valid) begin
        wr_en   = 1'b1;
        wr_addr = update_index;
        wr_data = upd_new;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) ctr_table[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      ptr      <= '0;
      ready    <= 1'b0;
      GHR      <= '0;
      GPresult <= 1'b0;
      GPvalid  <= 1'b0;
      GPindex  <= '0;
    end else begin
      case (state)
        INIT: begin
          GPvalid <= 1'b0;
          ptr     <= ptr + 1'b1;
          if (ptr == {HIST_BITS{1'b1}}) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          // Lookup sees the pre-edge counter even when the same entry is trained this edge.
          GPvalid <= lookup_valid;
          if (lookup_valid) begin
            GPresult <= ctr_table[GHR][1];
            GPindex  <= GHR;
          end
          if (update_valid) GHR <= {GHR[HIST_BITS-2:0], BranchTaken};
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_global_predictor.sv
// tb/tb_global_predictor.sv - scoreboard bench for global_predictor with HIST_BITS=4
// Stimulus pushes expected {GPresult, GPindex}; a negedge monitor pops on every GPvalid.
module tb_global_predictor;

  localparam int HB = 4;

  logic          clock;
  logic          reset;
  logic          ready;
  logic          lookup_valid;
  logic          GPresult;
  logic          GPvalid;
  logic [HB-1:0] GPindex;
  logic          update_valid;
  logic [HB-1:0] update_index;
  logic          BranchTaken;
  logic [HB-1:0] GHR;

  int checks = 0;
  int errors = 0;
  logic [HB:0] exp_q [$];

  // Order in which shifting in one bit per step walks the GHR through all 16 values.
  logic [HB-1:0] walk [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                               4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  global_predictor #(.HIST_BITS(HB)) dut (
    .clock        (clock),
    .reset        (reset),
    .ready        (ready),
    .lookup_valid (lookup_valid),
    .GPresult     (GPresult),
    .GPvalid      (GPvalid),
    .GPindex      (GPindex),
    .update_valid (update_valid),
    .update_index (update_index),
    .BranchTaken  (BranchTaken),
    .GHR          (GHR)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (GPvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_gpvalid: got GPvalid=1 with no lookup pending at %0t", $time);
      end else begin
        logic [HB:0] e;
        e = exp_q.pop_front();
        if ({GPresult, GPindex} !== e) begin
          errors++;
          $display("FAIL lookup: got result=%0b index=%0h expected result=%0b index=%0h at %0t",
                   GPresult, GPindex, e[HB], e[HB-1:0], $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check("reset_ready", ready, 0);
      check("reset_ghr", GHR, 0);
      check("reset_gpvalid", GPvalid, 0);
    end
    reset = 1'b0;
  endtask

  task automatic init_sweep(input bit junk);
    for (int i = 0; i < 16; i++) begin
      check("init_ready", ready, 0);
      check("init_ghr", GHR, 0);
      check("init_gpvalid", GPvalid, 0);
      check("init_gpresult", GPresult, 0);
      lookup_valid = junk;
      update_valid = junk;
      BranchTaken  = junk;
      update_index = 4'hF;
      tick();
    end
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    BranchTaken  = 1'b0;
    check("init_done_ready", ready, 1);
    check("init_done_ghr", GHR, 0);
  endtask

  task automatic step(input bit lk, input bit up, input logic [HB-1:0] idx, input bit taken,
                      input bit exp_res, input logic [HB-1:0] exp_idx, input logic [HB-1:0] exp_ghr);
    lookup_valid = lk;
    update_valid = up;
    update_index = idx;
    BranchTaken  = taken;
    if (lk) exp_q.push_back({exp_res, exp_idx});
    tick();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    check("ghr", GHR, exp_ghr);
  endtask

  initial begin
    reset = 1'b1; lookup_valid = 1'b0; update_valid = 1'b0;
    update_index = '0; BranchTaken = 1'b0;

    do_reset(3);
    init_sweep(1'b0);

    // Floor saturation at entry 0
    step(0, 1, 4'h0, 0, 0, 4'h0, 4'h0);
    step(0, 1, 4'h0, 0, 0, 4'h0, 4'h0);
    step(0, 1, 4'h0, 0, 0, 4'h0, 4'h0);
    step(1, 0, 4'h0, 0, 0, 4'h0, 4'h0);

    // Training entry F to strongly taken
    step(0, 1, 4'hF, 1, 0, 4'h0, 4'h1);
    step(0, 1, 4'hF, 1, 0, 4'h0, 4'h3);
    step(0, 1, 4'hF, 1, 0, 4'h0, 4'h7);
    step(0, 1, 4'hF, 1, 0, 4'h0, 4'hF);
    step(1, 0, 4'h0, 0, 1, 4'hF, 4'hF);
    check("gpvalid_single_cycle", GPvalid, 1);
    tick();
    check("gpvalid_drops", GPvalid, 0);
    check("gpresult_holds", GPresult, 1);

    // Hysteresis: read-old on simultaneous lookup/update, then weakly not-taken
    step(1, 1, 4'hF, 0, 1, 4'hF, 4'hE);
    step(0, 1, 4'hF, 0, 0, 4'h0, 4'hC);
    step(0, 1, 4'h0, 1, 0, 4'h0, 4'h9);
    step(0, 1, 4'h0, 1, 0, 4'h0, 4'h3);
    step(0, 1, 4'h0, 1, 0, 4'h0, 4'h7);
    step(0, 1, 4'h0, 1, 0, 4'h0, 4'hF);
    step(1, 0, 4'h0, 0, 0, 4'hF, 4'hF);

    // Push entry F back to strongly taken, then reset mid-lookup
    step(0, 1, 4'hF, 1, 0, 4'h0, 4'hF);
    step(0, 1, 4'hF, 1, 0, 4'h0, 4'hF);
    lookup_valid = 1'b1;
    do_reset(1);
    lookup_valid = 1'b0;
    init_sweep(1'b0);
    step(0, 1, 4'h0, 1, 0, 4'h0, 4'h1);
    step(0, 1, 4'h0, 1, 0, 4'h0, 4'h3);
    step(0, 1, 4'h0, 1, 0, 4'h0, 4'h7);
    step(0, 1, 4'h0, 1, 0, 4'h0, 4'hF);
    step(1, 0, 4'h0, 0, 0, 4'hF, 4'hF);

    // Inputs active throughout INIT, then every entry must read as cleared
    do_reset(1);
    init_sweep(1'b1);
    for (int i = 0; i < 15; i++) begin
      logic [HB-1:0] nxt;
      nxt = walk[i+1];
      step(1, 1, walk[i], nxt[0], 0, walk[i], nxt);
    end
    step(1, 0, 4'h0, 0, 0, 4'h8, 4'h8);

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/global_predictor.md
# global_predictor

Global-history branch predictor for the Alpha 21264 tournament predictor. It holds a global history register (GHR) and a table of 2^HIST_BITS 2-bit saturating counters, and issues a registered taken/not-taken prediction indexed by the GHR. It trains the addressed counter on branch resolution. It replaces the single shared Global2BitFSM counter with a history-indexed array, and feeds GPresult to the choice/tournament selection stage.

## Interface
- HIST_BITS, 12, GHR width; the table has 2^HIST_BITS entries.
- clock  in  1  rising-edge clock, single domain.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  table initialised; inputs are honoured only while ready=1.
- lookup_valid  in  1  request a prediction at the current GHR.
- GPresult  out  1  registered prediction (counter MSB).
- GPvalid  out  1  one-cycle pulse marking GPresult/GPindex valid.
- GPindex  out  HIST_BITS  GHR value used for the prediction, returned later as update_index.
- update_valid  in  1  branch resolved; train the counter and shift the GHR.
- update_index  in  HIST_BITS  table entry to train.
- BranchTaken  in  1  resolved outcome, 1 = taken.
- GHR  out  HIST_BITS  current history register.

## Operation
- States: INIT, RUN.
- reset=1 at an edge sets state=INIT, ptr=0, ready=0, GHR=0, GPresult=0, GPvalid=0, GPindex=0. No table write occurs on that edge. Reset held for several cycles keeps ptr at 0.
- INIT, reset=0:
  - Each edge writes table[ptr]=2'b00 and increments ptr.
  - At the edge that writes entry 2^HIST_BITS-1, state becomes RUN and ready becomes 1.
  - lookup_valid and update_valid are ignored: no GHR change, no GPvalid, no training.
- RUN, lookup_valid=1 at an edge: GPresult=table[GHR][1], GPindex=GHR, GPvalid=1.
- RUN, lookup_valid=0 at an edge: GPvalid=0; GPresult and GPindex hold their values.
- RUN, update_valid=1 at an edge:
  - table[update_index] takes the saturating update: taken gives min(c+1,3), not-taken gives max(c-1,0).
  - GHR={GHR[HIST_BITS-2:0], BranchTaken}.
- Counter encoding: 0 strongly not-taken, 1 weakly not-taken, 2 weakly taken, 3 strongly taken. The prediction is bit 1.
- Simultaneous lookup and update on the same edge:
  - The lookup uses the pre-edge GHR and the pre-edge counter value (read-old), including when update_index equals GHR.
  - Both actions complete on that edge.
- Back-to-back updates to the same index accumulate: each edge reads the value committed by the previous edge.
- The GHR wraps by shifting; its oldest bit is discarded.
- reset=1 mid-operation, in either state, aborts everything and restarts INIT from ptr=0. Any in-flight lookup produces no GPvalid.

## Timing
- Initialisation takes 2^HIST_BITS cycles: ready first reads 1 after the 2^HIST_BITS-th edge with reset=0 following the reset.
- Lookup latency is 1 cycle: GPvalid, GPresult and GPindex are visible after the edge that sampled lookup_valid.
- A lookup can be accepted every cycle.
- An update takes effect on the sampling edge; a lookup on the next edge sees it.
- The table is read combinationally and written synchronously. Each edge performs one write port access and two reads: one at update_index, one at GHR.

## Test plan
All scenarios use HIST_BITS=4 (16 entries).
- **Reset/init:** hold reset for 3 cycles, then release. Required: ready=0 for 16 edges and 1 after the 16th; GHR=0, GPvalid=0 and GPresult=0 throughout.
- **Training to taken:** 4 taken updates at update_index=0xF. Required: GHR steps 1,3,7,F and counter[F] steps 1,2,3,3. A following lookup gives GPresult=1, GPindex=0xF, and a single-cycle GPvalid.
- **Hysteresis:**
  - With GHR=0xF, apply update idx=0xF not-taken together with a lookup. Required: GPresult=1 (read-old), GHR becomes 0xE.
  - Apply one more not-taken update at idx 0xF (counter[F]=1), then 4 taken updates at idx 0x0 (GHR returns to 0xF).
  - A lookup then gives GPresult=0, GPindex=0xF.
- **Floor saturation:** 3 not-taken updates at idx 0x0 from 0. Required: counter stays 0 and a lookup at that index gives 0.
- **Inputs during INIT:** drive update_valid=1 with BranchTaken=1, and lookup_valid=1, every cycle of the sweep. Required: GPvalid never asserts, GHR stays 0, and every entry looks up as 0 after ready.
- **Reset mid-operation:** after the training scenario, assert reset for 1 cycle alongside lookup_valid. Required: no GPvalid, GHR=0, ready=0 for 16 edges, then a lookup at 0xF gives GPresult=0.
